divisor_sequencial: RTL
=======================

// Module: divisor_sequencial
// PURPOSE
//  Sequential restoring divider built around one shared subtrator instance.
//  FSM sequences the subtractor: one trial subtraction, one quotient bit per clock.
//  Unsigned N-bit dividend / N-bit divisor; start/busy/done handshake to the host.
//  Datapath reuse block for the SD122 arithmetic set.
// PARAMETERS
//  N    4    operand width (dividend, divisor, quotient, remainder); N >= 2
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  synchronous active-low reset
//  start      in   1  request; sampled only in IDLE
//  dividend   in   N  numerator, captured on accepted start
//  divisor    in   N  denominator, captured on accepted start
//  busy       out  1  1 from cycle after accepted start until done cycle (exclusive)
//  done       out  1  single-cycle pulse: results valid
//  quotient   out  N  held from done until next accepted start
//  remainder  out  N  held from done until next accepted start
//  div_zero   out  1  set with done when divisor==0; cleared on next accepted start
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-low.
//  Reset (rst_n=0 at edge): state=IDLE; busy, done, div_zero, quotient, remainder,
//   counter = 0. Reset mid-operation aborts silently; no done pulse.
//  States: IDLE, RUN, DONE.
//   IDLE -start & divisor!=0-> RUN: load Q=dividend, R=0, D=divisor, cnt=N.
//   IDLE -start & divisor==0-> DONE: quotient={N{1'b1}}, remainder=dividend, div_zero=1.
//   RUN  -cnt!=1-> RUN; RUN -cnt==1-> DONE (last iteration performed on this edge).
//   DONE -> IDLE unconditionally (done is high only while in DONE).
//  Iteration (each RUN edge), widths N+1 via subtrator #(N+1), B_in=0:
//   S = {R, Q[N-1]}; A=S, B={1'b0,D}; diff=subtrator D output, brw=B_out.
//   brw==0: R<=diff[N-1:0], Q<={Q[N-2:0],1'b1}; brw==1: R<=S[N-1:0], Q<={Q[N-2:0],1'b0}.
//   cnt<=cnt-1. R never exceeds D-1, so N bits always hold it.
//  Latency: start sampled at edge k -> done=1 in cycle after edge k+N (normal),
//   after edge k (div by zero). Throughput: one division per N+2 cycles.
//  busy=1 exactly in RUN. start while RUN or DONE: ignored, not queued.
//  Operand inputs may change freely after the accepting edge.
//  quotient/remainder ports driven from Q/R registers; values only meaningful with/after
//   done; previous results overwritten progressively once a new start is accepted.
//  Edge values: dividend<divisor -> q=0, r=dividend; divisor=1 -> q=dividend, r=0;
//   dividend=0 -> q=0, r=0 (normal N-cycle path).
// STRUCTURE
//  Shared package divisor_pkg: state encodings ST_IDLE/ST_RUN/ST_DONE (2-bit),
//   counter width function CNT_W = $clog2(N+1).
//  One sub-module: subtrator #(N+1) (existing borrow-ripple subtractor), B_in tied 0.
//  Everything else (FSM, Q/R/D registers, counter) flat in this module.
// TESTING (N=4, checks at done unless noted)
//  13/3, start 1 cycle -> busy 4 cycles, done 1 cycle, q=4, r=1, div_zero=0.
//  3/5 -> q=0, r=3; 15/15 -> q=1, r=0; 15/1 -> q=15, r=0.
//  7/0 -> done cycle after start edge, busy never 1, div_zero=1, q=15, r=7.
//  start 9/2, then start 6/3 held high during RUN and DONE -> only one done, q=4, r=1;
//   start still high in the following IDLE cycle is then accepted -> q=2, r=0.
//  start 14/4, rst_n=0 at 2nd RUN cycle -> next cycle all outputs 0, no done;
//   after release, 14/4 -> q=3, r=2.
//  Self-check: exhaustive 0..15 x 1..15 vs a/b, a%b; done exactly once per start.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared types for the sequential divider.
// State encoding and counter sizing helper.
package divisor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/subtrator.sv
// Borrow-ripple subtractor: D = A - B - B_in.
// B_out is the borrow out of the top bit.
module subtrator #(
   parameter int W = 5
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         B_in,
   output logic [W-1:0] D,
   output logic         B_out
);

   logic [W:0] bc;

   assign bc[0] = B_in;

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign D[i]    = A[i] ^ B[i] ^ bc[i];
      assign bc[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bc[i]);
   end

   assign B_out = bc[W];

endmodule

// File: rtl/divisor_sequencial.sv
// Restoring divider, one quotient bit per clock.
// A single shared subtrator does every trial subtraction.
module divisor_sequencial
   import divisor_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_zero
);

   localparam int CNT_W = cnt_w(N);

   state_t             state_q, state_d;
   logic [N-1:0]       q_q, q_d;
   logic [N-1:0]       r_q, r_d;
   logic [N-1:0]       d_q, d_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dz_q, dz_d;

   logic [N:0]         s;
   logic [N:0]         diff;
   logic               brw;
   logic               unused_msb;

   assign s = {r_q, q_q[N-1]};

   subtrator #(.W(N + 1)) u_sub (
      .A     (s),
      .B     ({1'b0, d_q}),
      .B_in  (1'b0),
      .D     (diff),
      .B_out (brw)
   );

   // Remainder stays below the divisor, so the top diff bit is never needed.
   assign unused_msb = diff[N];

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  q_d     = dividend;
                  r_d     = '0;
                  d_d     = divisor;
                  cnt_d   = CNT_W'(N);
                  dz_d    = 1'b0;
                  state_d = ST_RUN;
               end else begin
                  q_d     = '1;
                  r_d     = dividend;
                  d_d     = divisor;
                  dz_d    = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            r_d   = brw ? s[N-1:0] : diff[N-1:0];
            q_d   = {q_q[N-2:0], ~brw};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
      end
   end

   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign quotient  = q_q;
   assign remainder = r_q;
   assign div_zero  = dz_q;

endmodule
